fir_mac_control: RTL and testbench
==================================

FIR_MAC_CONTROL -- requirements
Module: fir_mac_control

Interface
REQ-001 Parameter N, default 25, data word width in bits (signed two's complement).
REQ-002 Parameter TAPS, default 5, number of filter taps (2..32).
REQ-003 Parameter FRAC, default 10, fractional bits of the fixed-point data and coefficient format.
REQ-004 clk  in  1  single system clock; all state updates on the rising edge.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 start  in  1  one-cycle strobe that requests processing of sample_in.
REQ-007 sample_in  in  N  signed input sample, captured on the accepted start.
REQ-008 coef_addr  out  clog2(TAPS)  tap index for the external coefficient ROM.
REQ-009 coef_in  in  N  signed coefficient, combinationally valid for the current coef_addr.
REQ-010 y_out  out  N  signed, saturated filter result, held until the next done.
REQ-011 acc_out  out  2N  raw accumulator value.
REQ-012 busy  out  1  high while the state is not IDLE.
REQ-013 done  out  1  one-cycle pulse when y_out updates.
REQ-014 overrun  out  1  sticky flag: start arrived while busy.

Function
REQ-015 FSM states: IDLE, MAC, OUT; encoding is defined in the shared package.
REQ-016 IDLE with start=1 at edge k: shift the delay line (x[0]<=sample_in, x[i]<=x[i-1]); clear the accumulator to 0; set tap index to 0; go to MAC.
REQ-017 MAC, edges k+1..k+TAPS: acc <= sat(acc + x[idx]*coef_in); idx increments; coef_addr = idx (combinational).
REQ-018 At the edge where idx = TAPS-1, the last product is added and the FSM goes to OUT.
REQ-019 OUT, edge k+TAPS+1: y_out <= sat_N(acc >>> FRAC); done=1 for exactly that cycle; go to IDLE.
REQ-020 Latency from the start edge to done high is TAPS+1 cycles; a new start is accepted in the cycle done is high.
REQ-021 Each product is the full 2N-bit signed product.
REQ-022 The accumulator addition saturates to the 2N-bit signed range (max 2^(2N-1)-1, min -2^(2N-1)); it does not wrap.
REQ-023 The output shift is arithmetic.
REQ-024 Values above 2^(N-1)-1 clamp to 2^(N-1)-1; values below -2^(N-1) clamp to -2^(N-1).
REQ-025 start while busy=1 is ignored: the delay line is unchanged and overrun is set to 1.
REQ-026 overrun clears only on reset.
REQ-027 When idle, acc_out and y_out hold their last values; coef_addr = 0.

Reset
REQ-028 reset=0 immediately forces: state IDLE, idx 0, all delay-line taps 0, acc 0, y_out 0, done 0, busy 0, overrun 0.
REQ-029 Reset asserted mid-MAC aborts the computation with no done pulse.
REQ-030 The first start after reset release is processed normally.

Structure
REQ-031 The shared package holds: the state enum, default N/TAPS/FRAC, and the saturation limit constants.
REQ-032 One sub-module, sat_add_2n: a combinational 2N-bit signed saturating adder, instantiated once for the accumulate path.
REQ-033 The delay line and the FSM are inline.

Verification (N=25, TAPS=5, FRAC=10)
REQ-034 Impulse: sample 1024 (1.0), all coefficients 512 (0.5) -> y_out=512 after 6 cycles; following four zero samples each give 512; fifth zero sample gives 0.
REQ-035 Latency/handshake: start at edge k -> busy=1 on k..k+5; done=1 only in the cycle after edge k+6; coef_addr sequence 0,1,2,3,4.
REQ-036 Saturation: delay line full of 2^24-1, coefficients 2^24-1 -> acc_out clamps at 2^49-1 (no sign flip); y_out = 2^24-1. Negative mirror gives -2^24.
REQ-037 Overrun: start again 2 cycles after an accepted start -> ignored; result matches a single-start run; overrun=1 and stays 1.
REQ-038 Reset mid-MAC: reset low at idx=2 -> all outputs 0 at once; done never pulses; a new start afterwards yields a correct result with a zeroed history.
REQ-039 Back-to-back: start asserted in the done cycle -> accepted with no overrun; two correct consecutive results.

Source files
------------

// File: rtl/fir_mac_control_pkg.sv
// Shared types and constants for the sequential FIR multiply-accumulate controller.
package fir_mac_control_pkg;

  typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

  localparam int N_DEF    = 25;
  localparam int TAPS_DEF = 5;
  localparam int FRAC_DEF = 10;

  // Saturation limits for the default word width (accumulator is 2N bits).
  localparam longint ACC_MAX_DEF = (64'sd1 <<< (2*N_DEF - 1)) - 64'sd1;
  localparam longint ACC_MIN_DEF = -(64'sd1 <<< (2*N_DEF - 1));
  localparam longint Y_MAX_DEF   = (64'sd1 <<< (N_DEF - 1)) - 64'sd1;
  localparam longint Y_MIN_DEF   = -(64'sd1 <<< (N_DEF - 1));

endpackage

// File: rtl/fir_mac_control_if.sv
// Sample/coefficient/result bundle between the FIR controller and its environment.
interface fir_mac_control_if
  import fir_mac_control_pkg::*;
#(
  parameter int N    = N_DEF,
  parameter int TAPS = TAPS_DEF
);
  localparam int AW = $clog2(TAPS);

  logic                  start;
  logic signed [N-1:0]   sample_in;
  logic [AW-1:0]         coef_addr;
  logic signed [N-1:0]   coef_in;
  logic signed [N-1:0]   y_out;
  logic signed [2*N-1:0] acc_out;
  logic                  busy;
  logic                  done;
  logic                  overrun;

  modport master (
    output start, sample_in, coef_in,
    input  coef_addr, y_out, acc_out, busy, done, overrun
  );

  modport slave (
    input  start, sample_in, coef_in,
    output coef_addr, y_out, acc_out, busy, done, overrun
  );

endinterface

// File: rtl/fir_mac_control_sat_add_2n.sv
// Combinational signed adder that clamps to the W-bit two's complement range instead of wrapping.
module sat_add_2n #(
  parameter int W = 50
) (
  input  logic signed [W-1:0] a,
  input  logic signed [W-1:0] b,
  output logic signed [W-1:0] sum
);

  logic [W:0] full;

  always_comb begin
    full = {a[W-1], a} + {b[W-1], b};
    // Top two bits disagree only on overflow; the carry-out bit gives the true sign.
    if (full[W] != full[W-1])
      sum = full[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    else
      sum = full[W-1:0];
  end

endmodule

// File: rtl/fir_mac_control.sv
// Sequential FIR filter: one tap per cycle through a saturating 2N-bit accumulator.
module fir_mac_control
  import fir_mac_control_pkg::*;
#(
  parameter int N    = N_DEF,
  parameter int TAPS = TAPS_DEF,
  parameter int FRAC = FRAC_DEF
) (
  input logic         clk,
  input logic         reset,
  fir_mac_control_if.slave bus
);

  localparam int W  = 2 * N;
  localparam int AW = $clog2(TAPS);
  localparam logic [AW-1:0] LAST = AW'(TAPS - 1);
  localparam logic signed [W-1:0] Y_MAX = {{(W-N+1){1'b0}}, {(N-1){1'b1}}};
  localparam logic signed [W-1:0] Y_MIN = {{(W-N+1){1'b1}}, {(N-1){1'b0}}};

  state_t state, state_next;

  logic signed [N-1:0] x [TAPS];
  logic [AW-1:0]       idx;
  logic signed [W-1:0] acc, prod, acc_next, shifted;
  logic signed [N-1:0] y_hold, y_sat;
  logic                done_pulse, overrun_flag;

  sat_add_2n #(.W(W)) u_acc_add (
    .a   (acc),
    .b   (prod),
    .sum (acc_next)
  );

  always_comb begin
    prod    = W'(x[idx]) * W'(bus.coef_in);
    shifted = acc >>> FRAC;
    if (shifted > Y_MAX)
      y_sat = Y_MAX[N-1:0];
    else if (shifted < Y_MIN)
      y_sat = Y_MIN[N-1:0];
    else
      y_sat = shifted[N-1:0];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      state <= IDLE;
    else
      state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (bus.start) state_next = MAC;
      MAC:     if (idx == LAST) state_next = OUT;
      OUT:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < TAPS; i++) x[i] <= '0;
      idx          <= '0;
      acc          <= '0;
      y_hold       <= '0;
      done_pulse   <= 1'b0;
      overrun_flag <= 1'b0;
    end else begin
      done_pulse <= (state == OUT);
      if (bus.start && state != IDLE) overrun_flag <= 1'b1;
      unique case (state)
        IDLE: if (bus.start) begin
          x[0] <= bus.sample_in;
          for (int unsigned i = 1; i < TAPS; i++) x[i] <= x[i-1];
          acc <= '0;
          idx <= '0;
        end
        MAC: begin
          acc <= acc_next;
          idx <= (idx == LAST) ? '0 : idx + AW'(1);
        end
        OUT:     y_hold <= y_sat;
        default: ;
      endcase
    end
  end

  assign bus.coef_addr = (state == MAC) ? idx : '0;
  assign bus.busy      = (state != IDLE);
  assign bus.done      = done_pulse;
  assign bus.overrun   = overrun_flag;
  assign bus.acc_out   = acc;
  assign bus.y_out     = y_hold;

endmodule

// File: tb/tb_fir_mac_control.sv
// Directed bench for fir_mac_control with a result scoreboard checked on every done pulse.
module tb_fir_mac_control;

  localparam int N    = 25;
  localparam int TAPS = 5;
  localparam int FRAC = 10;

  localparam longint M       = 64'sd16777215;          // 2^24-1
  localparam longint NEG_MIN = -64'sd16777216;         // -2^24
  localparam longint P       = 64'sd281474943156225;   // M*M
  localparam longint ACC_MAX = 64'sd562949953421311;   // 2^49-1
  localparam longint ACC_MIN = -64'sd562949953421312;  // -2^49

  typedef struct {
    longint y;
    longint acc;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  fir_mac_control_if #(.N(N), .TAPS(TAPS)) bus ();

  fir_mac_control #(.N(N), .TAPS(TAPS), .FRAC(FRAC)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic signed [N-1:0] coef_rom [TAPS];
  assign bus.coef_in = coef_rom[bus.coef_addr];

  int   checks = 0;
  int   errors = 0;
  exp_t q[$];
  exp_t mon_e;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic set_coefs(input longint c0, c1, c2, c3, c4);
    coef_rom[0] = N'(c0);
    coef_rom[1] = N'(c1);
    coef_rom[2] = N'(c2);
    coef_rom[3] = N'(c3);
    coef_rom[4] = N'(c4);
  endtask

  // Called at a falling edge; returns at the falling edge after the start edge.
  task automatic issue(input longint s, input bit expect_out, input longint ey, input longint eacc);
    exp_t e;
    if (expect_out) begin
      e.y   = ey;
      e.acc = eacc;
      q.push_back(e);
    end
    bus.start     = 1'b1;
    bus.sample_in = N'(s);
    @(negedge clk);
    bus.start     = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (bus.done !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check({name, "_done_seen"}, longint'(bus.done), 1);
  endtask

  always @(negedge clk) begin
    if (reset === 1'b1 && bus.done === 1'b1) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 expected no pending result");
      end else begin
        mon_e = q.pop_front();
        check("y_out", longint'(bus.y_out), mon_e.y);
        check("acc_out", longint'(bus.acc_out), mon_e.acc);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no completion expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset         = 1'b0;
    bus.start     = 1'b0;
    bus.sample_in = '0;
    set_coefs(512, 512, 512, 512, 512);
    repeat (3) @(negedge clk);
    check("rst_y_out", longint'(bus.y_out), 0);
    check("rst_acc_out", longint'(bus.acc_out), 0);
    check("rst_busy", longint'(bus.busy), 0);
    check("rst_done", longint'(bus.done), 0);
    check("rst_overrun", longint'(bus.overrun), 0);
    check("rst_coef_addr", longint'(bus.coef_addr), 0);
    reset = 1'b1;
    @(negedge clk);

    // Impulse with cycle-accurate handshake checks on the first result.
    issue(1024, 1, 512, 524288);
    check("lat_busy_0", longint'(bus.busy), 1);
    check("lat_coef_addr_0", longint'(bus.coef_addr), 0);
    for (int j = 1; j < 5; j++) begin
      @(negedge clk);
      check("lat_coef_addr", longint'(bus.coef_addr), j);
      check("lat_busy", longint'(bus.busy), 1);
      check("lat_done_early", longint'(bus.done), 0);
    end
    @(negedge clk);
    check("lat_busy_out", longint'(bus.busy), 1);
    check("lat_done_out", longint'(bus.done), 0);
    check("lat_coef_addr_out", longint'(bus.coef_addr), 0);
    @(negedge clk);
    check("lat_done", longint'(bus.done), 1);
    check("lat_busy_idle", longint'(bus.busy), 0);
    @(negedge clk);
    check("lat_done_pulse_end", longint'(bus.done), 0);

    for (int j = 0; j < 4; j++) begin
      issue(0, 1, 512, 524288);
      wait_done("impulse_tail");
    end
    issue(0, 1, 0, 0);
    wait_done("impulse_clear");

    // Positive saturation, then negative mirror.
    set_coefs(M, M, M, M, M);
    issue(M, 1, M, P);
    wait_done("sat1");
    issue(M, 1, M, 2 * P);
    wait_done("sat2");
    for (int j = 0; j < 3; j++) begin
      issue(M, 1, M, ACC_MAX);
      wait_done("sat_max");
    end
    set_coefs(NEG_MIN, NEG_MIN, NEG_MIN, NEG_MIN, NEG_MIN);
    issue(M, 1, NEG_MIN, ACC_MIN);
    wait_done("sat_min");
    check("overrun_clear", longint'(bus.overrun), 0);

    // Reset in the middle of a MAC sequence: no result expected.
    issue(12345, 0, 0, 0);
    n = 0;
    while (bus.coef_addr != 2 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("midmac_idx", longint'(bus.coef_addr), 2);
    #1 reset = 1'b0;
    #1;
    check("midmac_y_out", longint'(bus.y_out), 0);
    check("midmac_acc_out", longint'(bus.acc_out), 0);
    check("midmac_busy", longint'(bus.busy), 0);
    check("midmac_done", longint'(bus.done), 0);
    check("midmac_overrun", longint'(bus.overrun), 0);
    check("midmac_coef_addr", longint'(bus.coef_addr), 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // Fresh history, distinct taps; later starts are issued in the done cycle.
    set_coefs(512, 256, 128, 64, 32);
    issue(2048, 1, 1024, 1048576);
    wait_done("post_rst1");
    issue(3072, 1, 2048, 2097152);
    wait_done("post_rst2");
    issue(1000, 1, 1524, 1560576);
    wait_done("b2b1");
    issue(-2048, 1, -262, -268288);
    wait_done("b2b2");
    check("b2b_no_overrun", longint'(bus.overrun), 0);
    @(negedge clk);

    // Overrun: second start two cycles in must be dropped.
    issue(5, 1, -129, -131584);
    @(negedge clk);
    bus.start     = 1'b1;
    bus.sample_in = N'(7777);
    @(negedge clk);
    bus.start     = 1'b0;
    check("overrun_set", longint'(bus.overrun), 1);
    wait_done("overrun_run");
    check("overrun_sticky1", longint'(bus.overrun), 1);
    issue(0, 1, -97, -98560);
    wait_done("overrun_history");
    check("overrun_sticky2", longint'(bus.overrun), 1);

    repeat (4) @(negedge clk);
    check("scoreboard_empty", longint'(q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
